// File: rtl/rsbs_serial_if.sv
// Handshake and operand/result bundle for the serial reverse-subtract unit.
// The requester drives start/operands; the unit returns status, result and flags.
interface rsbs_serial_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             use_carry;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   modport master (
      output start, a, b, use_carry, carry_in,
      input  busy, done, result, flag_n, flag_z, flag_c, flag_v
   );

   modport slave (
      input  start, a, b, use_carry, carry_in,
      output busy, done, result, flag_n, flag_z, flag_c, flag_v
   );
endinterface

// File: rtl/rsbs_serial.sv
// Multi-cycle reverse subtract (b - a - borrow_in) with NZCV flags, CHUNK bits per clock,
// LSB chunk first, optional RSC borrow_in = ~carry_in.
module rsbs_serial #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic          clk,
   input logic          rst_n,
   rsbs_serial_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [KW-1:0]    k_q, k_d;
   logic             borrow_q, borrow_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             flag_n_q, flag_n_d;
   logic             flag_z_q, flag_z_d;
   logic             flag_c_q, flag_c_d;
   logic             flag_v_q, flag_v_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [CHUNK:0]   diff_s;
   logic [WIDTH-1:0] d_ext_s;
   logic [WIDTH-1:0] work_nxt_s;

   // Operands shift right one chunk per RUN cycle, so the active chunk always sits at the bottom;
   // the working register fills from the top so the last chunk lands in place.
   assign diff_s     = {1'b0, b_q[CHUNK-1:0]} - {1'b0, a_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow_q};
   assign d_ext_s    = WIDTH'(diff_s[CHUNK-1:0]);
   assign work_nxt_s = (work_q >> CHUNK) | (d_ext_s << (WIDTH - CHUNK));

   // Next-state, operand latch, chunk step and completion update.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      work_d   = work_q;
      result_d = result_q;
      k_d      = k_q;
      borrow_d = borrow_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;
      flag_v_d = flag_v_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               a_d      = bus.a;
               b_d      = bus.b;
               a_msb_d  = bus.a[WIDTH-1];
               b_msb_d  = bus.b[WIDTH-1];
               borrow_d = bus.use_carry ? ~bus.carry_in : 1'b0;
               work_d   = '0;
               k_d      = '0;
               state_d  = S_RUN;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RUN: begin
            a_d      = a_q >> CHUNK;
            b_d      = b_q >> CHUNK;
            work_d   = work_nxt_s;
            borrow_d = diff_s[CHUNK];
            if (k_q == KW'(NCHUNK - 1)) begin
               result_d = work_nxt_s;
               flag_n_d = work_nxt_s[WIDTH-1];
               flag_z_d = ~|work_nxt_s;
               flag_c_d = ~diff_s[CHUNK];
               flag_v_d = (a_msb_q != b_msb_q) && (work_nxt_s[WIDTH-1] != b_msb_q);
               k_d      = '0;
               state_d  = S_DONE;
            end else begin
               k_d      = k_q + KW'(1);
               state_d  = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         result_q <= '0;
         k_q      <= '0;
         borrow_q <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         flag_n_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         work_q   <= work_d;
         result_q <= result_d;
         k_q      <= k_d;
         borrow_q <= borrow_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         flag_n_q <= flag_n_d;
         flag_z_q <= flag_z_d;
         flag_c_q <= flag_c_d;
         flag_v_q <= flag_v_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.flag_n = flag_n_q;
   assign bus.flag_z = flag_z_q;
   assign bus.flag_c = flag_c_q;
   assign bus.flag_v = flag_v_q;
endmodule

// File: tb/tb_rsbs_serial.sv
// Bench for rsbs_serial: five parameterisations driven from shared stimulus and compared
// against a full-width arithmetic reference model.
module tb_rsbs_serial;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  start_v;
   logic [63:0] a_s, b_s;
   logic        uc_s, ci_s;

   logic [4:0]  busy_v, done_v;
   logic [63:0] res_v [5];
   logic [3:0]  flg_v [5];   // {n,z,c,v}

   int W  [5] = '{32, 32, 32, 32, 64};
   int NC [5] = '{4, 32, 8, 1, 4};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rsbs_serial_if #(.WIDTH(32)) if0 ();
   assign if0.start = start_v[0]; assign if0.a = a_s[31:0]; assign if0.b = b_s[31:0];
   assign if0.use_carry = uc_s; assign if0.carry_in = ci_s;
   rsbs_serial #(.WIDTH(32), .CHUNK(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   assign busy_v[0] = if0.busy; assign done_v[0] = if0.done; assign res_v[0] = 64'(if0.result);
   assign flg_v[0] = {if0.flag_n, if0.flag_z, if0.flag_c, if0.flag_v};

   rsbs_serial_if #(.WIDTH(32)) if1 ();
   assign if1.start = start_v[1]; assign if1.a = a_s[31:0]; assign if1.b = b_s[31:0];
   assign if1.use_carry = uc_s; assign if1.carry_in = ci_s;
   rsbs_serial #(.WIDTH(32), .CHUNK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   assign busy_v[1] = if1.busy; assign done_v[1] = if1.done; assign res_v[1] = 64'(if1.result);
   assign flg_v[1] = {if1.flag_n, if1.flag_z, if1.flag_c, if1.flag_v};

   rsbs_serial_if #(.WIDTH(32)) if2 ();
   assign if2.start = start_v[2]; assign if2.a = a_s[31:0]; assign if2.b = b_s[31:0];
   assign if2.use_carry = uc_s; assign if2.carry_in = ci_s;
   rsbs_serial #(.WIDTH(32), .CHUNK(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
   assign busy_v[2] = if2.busy; assign done_v[2] = if2.done; assign res_v[2] = 64'(if2.result);
   assign flg_v[2] = {if2.flag_n, if2.flag_z, if2.flag_c, if2.flag_v};

   rsbs_serial_if #(.WIDTH(32)) if3 ();
   assign if3.start = start_v[3]; assign if3.a = a_s[31:0]; assign if3.b = b_s[31:0];
   assign if3.use_carry = uc_s; assign if3.carry_in = ci_s;
   rsbs_serial #(.WIDTH(32), .CHUNK(32)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
   assign busy_v[3] = if3.busy; assign done_v[3] = if3.done; assign res_v[3] = 64'(if3.result);
   assign flg_v[3] = {if3.flag_n, if3.flag_z, if3.flag_c, if3.flag_v};

   rsbs_serial_if #(.WIDTH(64)) if4 ();
   assign if4.start = start_v[4]; assign if4.a = a_s; assign if4.b = b_s;
   assign if4.use_carry = uc_s; assign if4.carry_in = ci_s;
   rsbs_serial #(.WIDTH(64), .CHUNK(16)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   assign busy_v[4] = if4.busy; assign done_v[4] = if4.done; assign res_v[4] = if4.result;
   assign flg_v[4] = {if4.flag_n, if4.flag_z, if4.flag_c, if4.flag_v};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain full-width arithmetic; carry means no unsigned borrow.
   function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                 input logic uc, input logic ci,
                                 output logic [63:0] r, output logic [3:0] f);
      logic [63:0] mask, a, b;
      logic        bw, c;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      a    = a_in & mask;
      b    = b_in & mask;
      bw   = uc & ~ci;
      r    = (b - a - {63'd0, bw}) & mask;
      c    = ({2'b00, b} >= ({2'b00, a} + {65'd0, bw}));
      f    = {r[w-1], (r == 64'd0), c, (a[w-1] != b[w-1]) && (r[w-1] != b[w-1])};
   endfunction

   task automatic run_op(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic uc, input logic ci, input string tag);
      logic [63:0] er;
      logic [3:0]  ef;
      int          lat, bc;
      model(W[i], a, b, uc, ci, er, ef);
      @(negedge clk);
      a_s = a; b_s = b; uc_s = uc; ci_s = ci;
      start_v[i] = 1'b1;
      @(posedge clk);
      #1;
      start_v[i] = 1'b0;
      a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom};
      uc_s = 1'($urandom_range(0, 1)); ci_s = 1'($urandom_range(0, 1));
      lat = 0; bc = 0;
      while (done_v[i] !== 1'b1 && lat < 100) begin
         if (busy_v[i] === 1'b1) bc++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'(NC[i]));
      chk({tag, " busy_cycles"}, 64'(bc), 64'(NC[i]));
      chk({tag, " result"}, res_v[i], er);
      chk({tag, " flags"}, 64'(flg_v[i]), 64'(ef));
      @(posedge clk);
      #1;
      chk({tag, " done_one_cycle"}, 64'(done_v[i]), 64'd0);
   endtask

   initial begin
      int          t;
      int          n;
      int          pulse [3];
      logic [63:0] ra, rb;

      rst_n = 1'b0; start_v = 5'd0; a_s = 64'd0; b_s = 64'd0; uc_s = 1'b0; ci_s = 1'b0;
      #12;
      for (int i = 0; i < 5; i++) begin
         chk("reset busy", 64'(busy_v[i]), 64'd0);
         chk("reset done", 64'(done_v[i]), 64'd0);
         chk("reset result", res_v[i], 64'd0);
         chk("reset flags", 64'(flg_v[i]), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      run_op(0, 64'h5, 64'h3, 1'b0, 1'b0, "t_5_3");
      chk("t_5_3 const", res_v[0], 64'hFFFF_FFFE);
      chk("t_5_3 nzcv", 64'(flg_v[0]), 64'h8);
      run_op(0, 64'h1, 64'h1, 1'b0, 1'b0, "t_eq");
      chk("t_eq nzcv", 64'(flg_v[0]), 64'h6);
      run_op(0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, "t_ff");
      chk("t_ff const", res_v[0], 64'h2);
      run_op(0, 64'h7FFF_FFFF, 64'h8000_0001, 1'b0, 1'b0, "t_ovf");
      chk("t_ovf nzcv", 64'(flg_v[0]), 64'h3);
      run_op(0, 64'h1, 64'h100, 1'b0, 1'b0, "t_xchunk");
      chk("t_xchunk const", res_v[0], 64'hFF);
      run_op(0, 64'h1, 64'h1, 1'b1, 1'b0, "t_rsc0");
      chk("t_rsc0 const", res_v[0], 64'hFFFF_FFFF);
      run_op(0, 64'h1, 64'h1, 1'b1, 1'b1, "t_rsc1");
      chk("t_rsc1 nzcv", 64'(flg_v[0]), 64'h6);

      // start during RUN must be ignored
      @(negedge clk);
      a_s = 64'h5; b_s = 64'h3; uc_s = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      a_s = 64'h9; b_s = 64'h100; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      t = 0;
      while (done_v[0] !== 1'b1 && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("ignore lat", 64'(t), 64'd3);
      chk("ignore result", res_v[0], 64'hFFFF_FFFE);
      @(posedge clk); #1;
      chk("ignore no_requeue", 64'(busy_v[0]), 64'd0);

      // start held high: back-to-back with a done every NCHUNK+1 cycles
      @(negedge clk);
      a_s = 64'h1; b_s = 64'h100; start_v[0] = 1'b1;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done_v[0] === 1'b1 && n < 3) begin
            pulse[n] = c;
            n++;
         end
      end
      chk("b2b pulses", 64'(n), 64'd3);
      chk("b2b gap1", 64'(pulse[1] - pulse[0]), 64'd5);
      chk("b2b gap2", 64'(pulse[2] - pulse[1]), 64'd5);
      chk("b2b result", res_v[0], 64'hFF);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (8) @(posedge clk);

      // reset in the middle of RUN
      @(negedge clk);
      a_s = 64'h5; b_s = 64'h3; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst busy", 64'(busy_v[0]), 64'd0);
      chk("mid_rst result", res_v[0], 64'd0);
      chk("mid_rst flags", 64'(flg_v[0]), 64'd0);
      n = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done_v[0] === 1'b1) n++;
      end
      chk("mid_rst no_done", 64'(n), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) n++;
      end
      chk("post_rst idle", 64'(n), 64'd0);
      run_op(0, 64'h7FFF_FFFF, 64'h8000_0001, 1'b0, 1'b0, "post_rst");

      // randomized sweep over all parameterisations
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < ((i == 0) ? 200 : 1000); j++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op(i, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
